// File: rtl/up_down_count_decoder_pkg.sv
// up_down_count_decoder_pkg
//   Shared types and constants for the up/down counter bus receiver.
//   - state_t      : decoder state machine encoding (INIT, TRACK, ERROR)
//   - SYNC_DEPTH   : number of flops in the input synchronizer
//   - DIR_UP/DOWN  : encodings driven on UpOrDown
package up_down_count_decoder_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam int   SYNC_DEPTH = 2;
    localparam logic DIR_UP     = 1'b1;
    localparam logic DIR_DOWN   = 1'b0;

endpackage

// File: rtl/count_sync_filter.sv
// count_sync_filter
//   Brings an asynchronous multi-bit bus into the i_clk domain and
//   glitch-filters it. A value is offered on o_accept once it has been seen
//   on STABLE_CYCLES consecutive synchronized samples and either differs
//   from i_ref or i_accept_any is set.
//   Optional feature macro: UP_DOWN_COUNT_DECODER_FILTER_EN
//     defined   : stability filter built with STABLE_CYCLES
//     undefined : filter omitted, any synchronized value != i_ref accepted
//   Ports:
//     i_clk, i_rst   clock, async active-high reset
//     i_data         asynchronous input bus
//     i_ref          currently held value (acceptance requires a change)
//     i_accept_any   accept a stable value even if equal to i_ref
//     o_accept       one-cycle (combinational) accept strobe
//     o_value        value being accepted
import up_down_count_decoder_pkg::*;

module count_sync_filter #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_ref,
    input  logic             i_accept_any,
    output logic             o_accept,
    output logic [WIDTH-1:0] o_value
);

    logic [SYNC_DEPTH-1:0][WIDTH-1:0] r_sync;
    // Marks which synchronizer stages hold a real sample since reset, so the
    // reset value of the flops is never mistaken for a stable input.
    logic [SYNC_DEPTH-1:0]            r_vld;
    logic [WIDTH-1:0]                 w_synced;
    logic                             w_valid;
    logic                             w_stable;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_vld  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], i_data};
            r_vld  <= {r_vld[SYNC_DEPTH-2:0], 1'b1};
        end
    end

    assign w_synced = r_sync[SYNC_DEPTH-1];
    assign w_valid  = r_vld[SYNC_DEPTH-1];

`ifdef UP_DOWN_COUNT_DECODER_FILTER_EN
    localparam int RUN_W = $clog2(STABLE_CYCLES + 1) + 1;

    logic [WIDTH-1:0] r_cand;
    logic [RUN_W-1:0] r_run;
    logic [RUN_W-1:0] w_run;

    // w_run counts the current sample too, so acceptance happens on the
    // STABLE_CYCLES-th matching sample without an extra cycle of delay.
    always_comb begin
        w_run = '0;
        if (w_valid) begin
            if (w_synced != r_cand)
                w_run = RUN_W'(1);
            else if (r_run >= RUN_W'(STABLE_CYCLES))
                w_run = RUN_W'(STABLE_CYCLES);
            else
                w_run = r_run + RUN_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cand <= '0;
            r_run  <= '0;
        end else begin
            r_cand <= w_synced;
            r_run  <= w_run;
        end
    end

    assign w_stable = (w_run >= RUN_W'(STABLE_CYCLES));
`else
    // Without the filter every valid sample is immediately a candidate; a
    // non-positive STABLE_CYCLES is outside the legal range and disables it.
    assign w_stable = w_valid && (STABLE_CYCLES > 0);
`endif

    assign o_accept = w_stable && ((w_synced != i_ref) || i_accept_any);
    assign o_value  = w_synced;

endmodule

// File: rtl/up_down_count_decoder.sv
// up_down_count_decoder
//   Receiver for a ripple up/down counter bus. Synchronizes and filters the
//   count, then recovers direction, step pulses, wrap pulses and a signed
//   accumulated position. Jumps other than +/-1 (mod 2^WIDTH) set a sticky
//   error that ErrClr clears, re-baselining on the next accepted value.
//   Optional feature macro: UP_DOWN_COUNT_DECODER_FILTER_EN (see
//   count_sync_filter).
//   Ports:
//     Clk, reset   clock, async active-high reset
//     CountIn      asynchronous count bus
//     ErrClr       clear error and re-baseline
//     StepPulse    one-cycle pulse per accepted +/-1 step
//     UpOrDown     direction of last step (1 = up)
//     WrapUp       pulse on max -> 0 up step
//     WrapDown     pulse on 0 -> max down step
//     Position     signed accumulated step count (wraps)
//     CountOut     last accepted count
//     Err          sticky illegal-jump flag
import up_down_count_decoder_pkg::*;

module up_down_count_decoder #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 2,
    parameter int POS_WIDTH     = 16
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     CountIn,
    input  logic                 ErrClr,
    output logic                 StepPulse,
    output logic                 UpOrDown,
    output logic                 WrapUp,
    output logic                 WrapDown,
    output logic [POS_WIDTH-1:0] Position,
    output logic [WIDTH-1:0]     CountOut,
    output logic                 Err
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t                 r_state;
    logic                   r_step;
    logic                   r_dir;
    logic                   r_wrap_up;
    logic                   r_wrap_dn;
    logic [POS_WIDTH-1:0]   r_pos;
    logic [WIDTH-1:0]       r_count;
    logic                   r_err;

    logic                   w_accept;
    logic [WIDTH-1:0]       w_value;
    logic [WIDTH-1:0]       w_diff;

    count_sync_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .i_clk        (Clk),
        .i_rst        (reset),
        .i_data       (CountIn),
        .i_ref        (r_count),
        // CountOut resets to 0, so INIT must be able to take a stable 0.
        .i_accept_any (r_state == ST_INIT),
        .o_accept     (w_accept),
        .o_value      (w_value)
    );

    // Modulo-2^WIDTH difference: 1 is an up step, all-ones a down step.
    assign w_diff = w_value - r_count;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_INIT;
            r_step    <= 1'b0;
            r_dir     <= 1'b0;
            r_wrap_up <= 1'b0;
            r_wrap_dn <= 1'b0;
            r_pos     <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_step    <= 1'b0;
            r_wrap_up <= 1'b0;
            r_wrap_dn <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    if (w_accept) begin
                        r_count <= w_value;
                        r_state <= ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (w_accept) begin
                        r_count <= w_value;
                        if (w_diff == CNT_ONE) begin
                            r_step    <= 1'b1;
                            r_dir     <= DIR_UP;
                            r_pos     <= r_pos + POS_WIDTH'(1);
                            r_wrap_up <= (r_count == CNT_MAX);
                        end else if (w_diff == CNT_MAX) begin
                            r_step    <= 1'b1;
                            r_dir     <= DIR_DOWN;
                            r_pos     <= r_pos - POS_WIDTH'(1);
                            r_wrap_dn <= (r_count == '0);
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_ERROR;
                        end
                    end
                end
                ST_ERROR: begin
                    if (w_accept)
                        r_count <= w_value;
                    if (ErrClr) begin
                        r_err   <= 1'b0;
                        r_state <= ST_INIT;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign StepPulse = r_step;
    assign UpOrDown  = r_dir;
    assign WrapUp    = r_wrap_up;
    assign WrapDown  = r_wrap_dn;
    assign Position  = r_pos;
    assign CountOut  = r_count;
    assign Err       = r_err;

endmodule

// File: tb/tb_up_down_count_decoder.sv
module tb_up_down_count_decoder;

    logic        Clk = 1'b0;
    logic        reset;
    logic [3:0]  CountIn;
    logic        ErrClr;
    logic        StepPulse, UpOrDown, WrapUp, WrapDown, Err;
    logic [15:0] Position;
    logic [3:0]  CountOut;

    int n_cmp = 0;
    int n_bad = 0;
    int n_step = 0;
    int n_wu = 0;
    int n_wd = 0;

    up_down_count_decoder #(.WIDTH(4), .STABLE_CYCLES(2), .POS_WIDTH(16)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .CountIn   (CountIn),
        .ErrClr    (ErrClr),
        .StepPulse (StepPulse),
        .UpOrDown  (UpOrDown),
        .WrapUp    (WrapUp),
        .WrapDown  (WrapDown),
        .Position  (Position),
        .CountOut  (CountOut),
        .Err       (Err)
    );

    always #5 Clk = ~Clk;

    // Pulses are one full cycle wide, so each is seen on exactly one negedge.
    always @(negedge Clk) begin
        if (StepPulse) n_step++;
        if (WrapUp)    n_wu++;
        if (WrapDown)  n_wd++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic clr_cnt();
        n_step = 0;
        n_wu   = 0;
        n_wd   = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        CountIn = v;
        tick(n);
    endtask

    initial begin
        reset   = 1'b1;
        CountIn = 4'd5;
        ErrClr  = 1'b0;
        tick(2);
        check("rst_countout", CountOut, 0);
        check("rst_position", Position, 0);
        check("rst_err", Err, 0);
        check("rst_step", StepPulse, 0);

        // Reset baseline at 5
        reset = 1'b0;
        clr_cnt();
        tick(4);
        check("base_countout", CountOut, 5);
        check("base_steps", n_step, 0);
        check("base_position", Position, 0);
        check("base_err", Err, 0);

        // Up run 5 -> 15 -> 0 -> 1
        clr_cnt();
        for (int v = 6; v <= 17; v++) hold(4'(v), 10);
        check("up_steps", n_step, 12);
        check("up_dir", UpOrDown, 1);
        check("up_wrapup", n_wu, 1);
        check("up_wrapdn", n_wd, 0);
        check("up_position", Position, 12);
        check("up_countout", CountOut, 1);

        // Down run 1 -> 0 -> 15 -> 14
        clr_cnt();
        hold(4'd0, 10);
        hold(4'd15, 10);
        hold(4'd14, 10);
        check("dn_steps", n_step, 3);
        check("dn_dir", UpOrDown, 0);
        check("dn_wrapdn", n_wd, 1);
        check("dn_position", Position, 9);

        // Back up to 3: 15, 0, 1, 2, 3
        clr_cnt();
        for (int v = 15; v <= 19; v++) hold(4'(v), 10);
        check("up2_steps", n_step, 5);
        check("up2_position", Position, 14);
        check("up2_countout", CountOut, 3);

        // One-cycle glitch 3 -> 7 -> 3
        clr_cnt();
        CountIn = 4'd7;
        tick(1);
        hold(4'd3, 10);
`ifdef UP_DOWN_COUNT_DECODER_FILTER_EN
        check("glitch_err", Err, 0);
        check("glitch_steps", n_step, 0);
`else
        // Unfiltered: the glitch is seen as an illegal jump; recover.
        check("glitch_err", Err, 1);
        check("glitch_steps", n_step, 0);
        ErrClr = 1'b1;
        tick(1);
        ErrClr = 1'b0;
        tick(10);
        check("glitch_clr_err", Err, 0);
`endif
        check("glitch_countout", CountOut, 3);
        check("glitch_position", Position, 14);

        // Illegal jump 3 -> 6, then 6 -> 7 in ERROR
        clr_cnt();
        hold(4'd6, 10);
        check("ill_err", Err, 1);
        check("ill_countout", CountOut, 6);
        check("ill_position", Position, 14);
        hold(4'd7, 10);
        check("ill_err_steps", n_step, 0);
        check("ill_err_countout", CountOut, 7);
        check("ill_err_still", Err, 1);
        ErrClr = 1'b1;
        tick(1);
        ErrClr = 1'b0;
        check("clr_err", Err, 0);
        tick(5);
        check("clr_countout", CountOut, 7);
        check("clr_steps", n_step, 0);
        hold(4'd8, 10);
        check("post_clr_steps", n_step, 1);
        check("post_clr_dir", UpOrDown, 1);
        check("post_clr_position", Position, 15);
        check("post_clr_countout", CountOut, 8);

        // Async reset mid-run, between clock edges
        CountIn = 4'd9;
        tick(2);
        #2;
        reset = 1'b1;
        #1;
        check("arst_countout", CountOut, 0);
        check("arst_position", Position, 0);
        check("arst_dir", UpOrDown, 0);
        check("arst_err", Err, 0);
        tick(2);
        reset = 1'b0;
        clr_cnt();
        tick(6);
        check("rebase_countout", CountOut, 9);
        check("rebase_position", Position, 0);
        check("rebase_steps", n_step, 0);

        // Down step below zero: Position goes to -1
        hold(4'd8, 10);
        check("neg_steps", n_step, 1);
        check("neg_dir", UpOrDown, 0);
        check("neg_position", Position, 32'h0000ffff);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/up_down_count_decoder.md
# up_down_count_decoder

- Receiving end of the 4-bit up/down counter bus: samples the `Count` value produced by the asynchronous (ripple) up/down counter, which is unrelated to `Clk`.
- Synchronizes and glitch-filters that value, then recovers the direction the counter is running, per-step pulses, wrap events and an accumulated signed position.
- Flags any illegal jump (a change other than ±1 modulo 2^WIDTH) as an error.
- Sits between the counter and any logic that needs a clean, `Clk`-domain view of counter motion.

## Interface
Parameters:
- `WIDTH`, 4: width of the observed count bus.
- `STABLE_CYCLES`, 2: consecutive equal synchronized samples required to accept a new value; legal range ≥ 1.
- `POS_WIDTH`, 16: width of the accumulated position register.

Ports:
- `Clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `CountIn`  in  WIDTH  asynchronous count bus from the up/down counter.
- `ErrClr`  in  1  synchronous pulse; clears the error and re-baselines.
- `StepPulse`  out  1  one-cycle pulse per accepted ±1 step.
- `UpOrDown`  out  1  direction of last accepted step; 1 = up, 0 = down.
- `WrapUp`  out  1  one-cycle pulse, coincident with `StepPulse`, on an up step from 2^WIDTH−1 to 0.
- `WrapDown`  out  1  one-cycle pulse, coincident with `StepPulse`, on a down step from 0 to 2^WIDTH−1.
- `Position`  out  POS_WIDTH  signed accumulated step count.
- `CountOut`  out  WIDTH  last accepted (filtered) count value.
- `Err`  out  1  sticky illegal-jump flag.

## Operation
- **Input path:** `CountIn` → 2-flop synchronizer → stability filter. The filter holds a candidate and a run counter; the candidate is accepted once seen on STABLE_CYCLES consecutive cycles and differs from `CountOut`.
- **States:** INIT, TRACK, ERROR.
- **INIT:** the first accepted value loads `CountOut`; no step, no position change; next state is TRACK.
- **TRACK:** compute diff = new − CountOut, modulo 2^WIDTH.
  - diff == 1: up step. Assert `StepPulse`, `UpOrDown`=1, `Position`+1.
  - diff == 2^WIDTH−1: down step. Assert `StepPulse`, `UpOrDown`=0, `Position`−1.
  - Any other diff: set `Err`, go to ERROR; `Position` and `UpOrDown` are unchanged.
  - `CountOut` takes the new value in every case.
- **ERROR:** accepted values still update `CountOut`, but produce no steps and no position change. `ErrClr` clears `Err` and goes to INIT.
- **Position:** wraps modulo 2^POS_WIDTH, two's complement, with no saturation.
- **Simultaneous events:** if `ErrClr` coincides with a new illegal jump (only possible while in INIT → TRACK), the error wins. `ErrClr` in TRACK has no effect.
- **Reset mid-operation:** all state discarded immediately; the next accepted value re-baselines via INIT.

## Timing
- **Reset values:** all outputs 0, state INIT, synchronizer and filter cleared. Because `CountOut`=0 after reset, an input held at 0 is never "accepted" as a change; INIT therefore also accepts a stable value equal to 0 after STABLE_CYCLES samples.
- **Latency:** a `CountIn` change setting up before edge k produces `StepPulse` in the cycle after edge k+STABLE_CYCLES+1. That is STABLE_CYCLES+2 cycles; 4 cycles at the default.
- **Updates:** `StepPulse`, `WrapUp` and `WrapDown` are registered one-cycle pulses. `Position`, `UpOrDown` and `CountOut` update on the same edge that raises `StepPulse`.
- **Throughput:** at most one accepted value per STABLE_CYCLES cycles. Input changes faster than that are filtered, and may show up later as an illegal jump.
- **Error timing:** `Err` rises on the edge where the bad value is accepted and falls on the edge after `ErrClr` is sampled.

## Configuration
- **`UP_DOWN_COUNT_DECODER_FILTER_EN`**
  - **Defined:** the stability filter is built with `STABLE_CYCLES` as specified.
  - **Undefined:** the filter is omitted. Every synchronized value that differs from `CountOut` is accepted, i.e. behaviour and latency equal `STABLE_CYCLES`=1 (latency 3 cycles), and the `STABLE_CYCLES` parameter is ignored.

## Structure
- **Package `up_down_count_decoder_pkg`:**
  - state enum (INIT, TRACK, ERROR);
  - localparams for synchronizer depth (2) and the up/down direction encodings.
- **Sub-module `count_sync_filter`:** 2-flop synchronizer plus stability filter. It outputs the `accept` strobe and the accepted value, and is reused for any other asynchronous bus the team samples.
- **Top level:** state machine, diff/wrap logic and position accumulator.

## Test plan
- **Reset baseline:** reset high then low, `CountIn` held at 5 → after 4 cycles `CountOut`=5, no `StepPulse`, `Position`=0, `Err`=0.
- **Up run:** `CountIn` steps 5→6→…→15→0→1, each value held 10 cycles → 12 `StepPulse`s, `UpOrDown`=1, exactly one `WrapUp` (at 15→0), `Position`=12.
- **Down run:** from 1, step down to 14 → 3 `StepPulse`s, `UpOrDown`=0, one `WrapDown` at 0→15, `Position`=9.
- **Glitch rejection:** 1-cycle pulse of `CountIn` from 3 to 7, then back to 3 → no acceptance, `Err`=0, no `StepPulse`.
- **Illegal jump:** 3→6 held → `Err`=1 and `CountOut`=6. Then 6→7 gives no step. Then pulse `ErrClr` and step 7→8 → `CountOut`=7 after the `ErrClr` re-baseline and `Err`=0; 7→8 gives one up `StepPulse`, `Position` previous +1.
- **Async reset mid-run:** assert `reset` between `Clk` edges during an up run → all outputs 0 immediately. After release with `CountIn`=9: re-baseline `CountOut`=9, `Position`=0.
